// File: rtl/pwm_gen_array.sv
// Multi-channel PWM generator with per-channel cycle, counter and period-aligned duty/phase shadows.
// Optional output-enable input OE is compiled in when PWM_GEN_ARRAY_OE_EN is defined.
module pwm_gen_array #(
  parameter int WIDTH          = 13,
  parameter int CHANNELS       = 4,
  parameter     PHASE_INVERTED = "TRUE"
) (
  input  logic                                            CLK,
  input  logic                                            RST,
`ifdef PWM_GEN_ARRAY_OE_EN
  input  logic                                            OE,
`endif
  input  logic                                            SYNC,
  input  logic                                            SET,
  input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] SET_CH,
  input  logic [WIDTH-1:0]                                CYCLE,
  input  logic [CHANNELS*WIDTH-1:0]                       DUTY,
  input  logic [CHANNELS*WIDTH-1:0]                       PHASE,
  output logic [CHANNELS-1:0]                             PWM_OUT
);

  localparam logic [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] TWO_W  = {{(WIDTH-2){1'b0}}, 2'b10};
  localparam bit               INV    = (PHASE_INVERTED == "TRUE");

  logic oe_s;
`ifdef PWM_GEN_ARRAY_OE_EN
  assign oe_s = OE;
`else
  assign oe_s = 1'b1;
`endif

  // Level of one channel for counter value t; the subtraction keeps a sign bit so a
  // negative offset can be folded back into [0, C) by adding C once.
  function automatic logic pwm_level(input logic [WIDTH-1:0] t,
                                     input logic [WIDTH-1:0] d,
                                     input logic [WIDTH-1:0] p,
                                     input logic [WIDTH-1:0] c);
    logic [WIDTH-1:0] p_clamp;
    logic [WIDTH-1:0] start;
    logic [WIDTH:0]   diff;
    logic             lvl;
    p_clamp = (p > (c - ONE_W)) ? (c - ONE_W) : p;
    if (INV) begin
      start = (p_clamp == ZERO_W) ? ZERO_W : (c - p_clamp);
    end else begin
      start = p_clamp;
    end
    diff = {1'b0, t} - {1'b0, start};
    if (diff[WIDTH]) begin
      diff = diff + {1'b0, c};
    end else begin
      diff = diff;
    end
    if (c < TWO_W) begin
      lvl = 1'b0;
    end else begin
      lvl = (diff[WIDTH-1:0] < d);
    end
    return lvl;
  endfunction

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    logic             set_hit_s;
    logic [WIDTH-1:0] cyc_q, cyc_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] duty_q, phase_q;
    logic             pwm_q, pwm_d;

    assign set_hit_s  = SET && (int'(SET_CH) == g);
    assign PWM_OUT[g] = pwm_q;

    // Next cycle, counter and output level; SYNC/SET restart ahead of the wrap.
    always_comb begin
      cyc_d = set_hit_s ? CYCLE : cyc_q;
      if (SYNC || set_hit_s) begin
        cnt_d = ZERO_W;
      end else if (cyc_q < TWO_W) begin
        cnt_d = ZERO_W;
      end else if (cnt_q >= (cyc_q - ONE_W)) begin
        cnt_d = ZERO_W;
      end else begin
        cnt_d = cnt_q + ONE_W;
      end
      pwm_d = oe_s & pwm_level(cnt_q, duty_q, phase_q, cyc_q);
    end

    // Channel state; shadows reload only when the counter lands on zero.
    always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
        cyc_q   <= ZERO_W;
        cnt_q   <= ZERO_W;
        duty_q  <= ZERO_W;
        phase_q <= ZERO_W;
        pwm_q   <= 1'b0;
      end else begin
        cyc_q <= cyc_d;
        cnt_q <= cnt_d;
        pwm_q <= pwm_d;
        if (cnt_d == ZERO_W) begin
          duty_q  <= DUTY[g*WIDTH +: WIDTH];
          phase_q <= PHASE[g*WIDTH +: WIDTH];
        end else begin
          duty_q  <= duty_q;
          phase_q <= phase_q;
        end
      end
    end
  end

endmodule

// File: tb/tb_pwm_gen_array.sv
// Bench for pwm_gen_array: one inverted-phase and one plain-phase instance share stimulus,
// an arithmetic model predicts both outputs every cycle, directed literals pin the model.
module tb_pwm_gen_array;
  localparam int W  = 13;
  localparam int CH = 4;

  logic          CLK = 1'b0;
  logic          RST;
  logic          SYNC, SET;
  logic [1:0]    SET_CH;
  logic [W-1:0]  CYCLE;
  logic [CH*W-1:0] DUTY, PHASE;
  logic [CH-1:0] pwm_t, pwm_f;
  logic          oe_m;
`ifdef PWM_GEN_ARRAY_OE_EN
  logic          OE;
  assign oe_m = OE;
`else
  assign oe_m = 1'b1;
`endif

  int total = 0;
  int bad   = 0;
  bit chk   = 1'b0;

  always #5 CLK = ~CLK;

  pwm_gen_array #(.WIDTH(W), .CHANNELS(CH), .PHASE_INVERTED("TRUE")) u_dut_t (
    .CLK(CLK), .RST(RST),
`ifdef PWM_GEN_ARRAY_OE_EN
    .OE(OE),
`endif
    .SYNC(SYNC), .SET(SET), .SET_CH(SET_CH), .CYCLE(CYCLE),
    .DUTY(DUTY), .PHASE(PHASE), .PWM_OUT(pwm_t));

  pwm_gen_array #(.WIDTH(W), .CHANNELS(CH), .PHASE_INVERTED("FALSE")) u_dut_f (
    .CLK(CLK), .RST(RST),
`ifdef PWM_GEN_ARRAY_OE_EN
    .OE(OE),
`endif
    .SYNC(SYNC), .SET(SET), .SET_CH(SET_CH), .CYCLE(CYCLE),
    .DUTY(DUTY), .PHASE(PHASE), .PWM_OUT(pwm_f));

  // Reference model: integer state per channel, output from the modular-distance rule.
  int mC[CH], mT[CH], mD[CH], mP[CH];
  logic [CH-1:0] exp_t = '0;
  logic [CH-1:0] exp_f = '0;

  function automatic bit lvl(int t, int d, int p, int c, bit inv);
    int pp, s;
    if (c < 2) return 1'b0;
    pp = (p < c) ? p : c - 1;
    s  = inv ? (c - pp) % c : pp;
    return ((t - s + c) % c) < d;
  endfunction

  function automatic int nxt_t(int i);
    bit hit;
    int c;
    hit = SET && (int'(SET_CH) == i);
    c   = hit ? int'(CYCLE) : mC[i];
    if (SYNC || hit || c < 2) return 0;
    return (mT[i] + 1) % c;
  endfunction

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < CH; i++) begin
        mC[i] <= 0; mT[i] <= 0; mD[i] <= 0; mP[i] <= 0;
      end
      exp_t <= '0;
      exp_f <= '0;
    end else begin
      for (int i = 0; i < CH; i++) begin
        exp_t[i] <= oe_m && lvl(mT[i], mD[i], mP[i], mC[i], 1'b1);
        exp_f[i] <= oe_m && lvl(mT[i], mD[i], mP[i], mC[i], 1'b0);
        if (SET && int'(SET_CH) == i) mC[i] <= int'(CYCLE);
        mT[i] <= nxt_t(i);
        if (nxt_t(i) == 0) begin
          mD[i] <= int'(DUTY[i*W +: W]);
          mP[i] <= int'(PHASE[i*W +: W]);
        end
      end
    end
  end

  always @(negedge CLK) begin
    if (chk) begin
      total++;
      if (pwm_t !== exp_t) begin
        bad++;
        $display("FAIL model_inv at %0t: dut=%b required=%b", $time, pwm_t, exp_t);
      end
      total++;
      if (pwm_f !== exp_f) begin
        bad++;
        $display("FAIL model_noinv at %0t: dut=%b required=%b", $time, pwm_f, exp_f);
      end
    end
  end

  task automatic check_lit(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic wait_t(input int ch, input int x);
    int n = 0;
    while (mT[ch] != x && n < 12000) begin
      @(negedge CLK);
      n++;
    end
    if (mT[ch] != x) check_lit("wait_timeout", mT[ch], x);
  endtask

  task automatic spot(input bit inv, input int ch, input int x, input int req);
    wait_t(ch, x);
    @(negedge CLK);
    check_lit(inv ? "spot_inv" : "spot_noinv", inv ? int'(pwm_t[ch]) : int'(pwm_f[ch]), req);
  endtask

  task automatic set_cycle(input int ch, input int c);
    SET_CH = 2'(ch);
    CYCLE  = W'(c);
    SET    = 1'b1;
    @(negedge CLK);
    SET    = 1'b0;
  endtask

  task automatic count_hi(input int n, input int chg, input int nd, output int h0, output int h1);
    h0 = 0;
    h1 = 0;
    for (int k = 0; k < n; k++) begin
      if (k == chg) DUTY[0 +: W] = W'(nd);
      h0 += int'(pwm_t[0]);
      h1 += int'(pwm_t[1]);
      @(negedge CLK);
    end
  endtask

  initial begin
    int h0, h1;
    RST = 1'b1; SYNC = 1'b0; SET = 1'b0; SET_CH = 2'd0; CYCLE = '0;
    DUTY = '0; PHASE = '0;
`ifdef PWM_GEN_ARRAY_OE_EN
    OE = 1'b1;
`endif
    repeat (3) @(negedge CLK);
    chk = 1'b1;
    check_lit("reset_out", int'(pwm_t) + int'(pwm_f), 0);
    RST = 1'b0;
    repeat (5) @(negedge CLK);
    check_lit("unconfigured_out", int'(pwm_t) + int'(pwm_f), 0);

    // Basic duty, C=5000, D=2500, P=0
    DUTY[0 +: W] = 13'd2500;
    set_cycle(0, 5000);
    @(negedge CLK);
    count_hi(5000, -1, 0, h0, h1);
    check_lit("basic_high_count", h0, 2500);
    spot(1'b1, 0, 2499, 1);
    spot(1'b1, 0, 2500, 0);
    spot(1'b1, 0, 4999, 0);
    spot(1'b1, 0, 0, 1);

    // Phase 1000: inverted start 4000, plain start 1000
    PHASE[0 +: W] = 13'd1000;
    wait_t(0, 0);
    spot(1'b0, 0, 999, 0);
    spot(1'b0, 0, 1000, 1);
    spot(1'b1, 0, 1499, 1);
    spot(1'b1, 0, 1500, 0);
    spot(1'b0, 0, 3499, 1);
    spot(1'b0, 0, 3500, 0);
    spot(1'b1, 0, 3999, 0);
    spot(1'b1, 0, 4000, 1);

    // Mid-period duty change on ch0 while ch1 runs C=200, D=50
    PHASE[0 +: W] = 13'd0;
    DUTY[W +: W]  = 13'd50;
    set_cycle(1, 200);
    wait_t(0, 1);
    count_hi(5000, 1199, 1000, h0, h1);
    check_lit("mid_update_old_period", h0, 2500);
    check_lit("ch1_independent_a", h1, 1250);
    count_hi(5000, -1, 0, h0, h1);
    check_lit("mid_update_new_period", h0, 1000);
    check_lit("ch1_independent_b", h1, 1250);

    // Boundaries on a 50-clock period
    DUTY[0 +: W] = 13'd0;
    set_cycle(0, 50);
    @(negedge CLK);
    count_hi(50, -1, 0, h0, h1);
    check_lit("duty0_low", h0, 0);
    DUTY[0 +: W] = 13'd50;
    @(negedge CLK);
    wait_t(0, 1);
    count_hi(50, -1, 0, h0, h1);
    check_lit("duty_eq_c_high", h0, 50);
    DUTY[0 +: W] = 13'd8191;
    @(negedge CLK);
    wait_t(0, 1);
    count_hi(50, -1, 0, h0, h1);
    check_lit("duty_max_high", h0, 50);
    DUTY[0 +: W]  = 13'd10;
    PHASE[0 +: W] = 13'd6000;
    @(negedge CLK);
    wait_t(0, 0);
    spot(1'b1, 0, 0, 0);
    spot(1'b1, 0, 1, 1);
    spot(1'b0, 0, 8, 1);
    spot(1'b0, 0, 9, 0);
    spot(1'b1, 0, 10, 1);
    spot(1'b1, 0, 11, 0);
    spot(1'b0, 0, 48, 0);
    spot(1'b0, 0, 49, 1);
    DUTY[0 +: W]  = 13'd8191;
    PHASE[0 +: W] = 13'd0;
    set_cycle(0, 1);
    count_hi(20, -1, 0, h0, h1);
    check_lit("cycle1_low", h0, 0);
    set_cycle(0, 0);
    count_hi(20, -1, 0, h0, h1);
    check_lit("cycle0_low", h0, 0);

    // SYNC at t=3000 reloads shadows on every channel
    DUTY[0 +: W] = 13'd2500;
    set_cycle(0, 5000);
    wait_t(0, 3000);
    DUTY[0 +: W] = 13'd700;
    SYNC = 1'b1;
    @(negedge CLK);
    SYNC = 1'b0;
    check_lit("sync_t0_ch0", mT[0], 0);
    @(negedge CLK);
    count_hi(5000, -1, 0, h0, h1);
    check_lit("sync_ch0_count", h0, 700);
    check_lit("sync_ch1_count", h1, 1250);

    // SYNC together with SET of ch1 to C=100
    SET_CH = 2'd1; CYCLE = 13'd100; SET = 1'b1; SYNC = 1'b1;
    @(negedge CLK);
    SET = 1'b0; SYNC = 1'b0;
    @(negedge CLK);
    count_hi(5000, -1, 0, h0, h1);
    check_lit("sync_set_ch1", h1, 2500);
    check_lit("sync_set_ch0", h0, 700);

    // Asynchronous reset mid-period
    wait_t(1, 10);
    #2;
    RST = 1'b1;
    #1;
    check_lit("rst_async_inv", int'(pwm_t), 0);
    check_lit("rst_async_noinv", int'(pwm_f), 0);
    @(negedge CLK);
    RST = 1'b0;
    count_hi(100, -1, 0, h0, h1);
    check_lit("post_rst_ch0", h0, 0);
    check_lit("post_rst_ch1", h1, 0);
    set_cycle(0, 50);
    @(negedge CLK);
    count_hi(50, -1, 0, h0, h1);
    check_lit("post_rst_reconfig", h0, 50);

`ifdef PWM_GEN_ARRAY_OE_EN
    DUTY[0 +: W] = 13'd2500;
    set_cycle(0, 5000);
    wait_t(0, 100);
    OE = 1'b0;
    @(negedge CLK);
    check_lit("oe_off", int'(pwm_t[0]), 0);
    repeat (299) @(negedge CLK);
    OE = 1'b1;
    @(negedge CLK);
    check_lit("oe_on", int'(pwm_t[0]), 1);
    repeat (10) @(negedge CLK);
`endif

    chk = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pwm_gen_array.md
# pwm_gen_array

Multi-channel successor to the single-channel PWM generator: `CHANNELS` independent PWM outputs, each with its own cycle register, free-running period counter and double-buffered duty/phase. Duty and phase are latched into shadow registers only at period boundaries, so every output edge is glitch-free. The block sits between the modulation/STM datapath, which drives duty and phase, and the transducer output pins.

## Interface
Parameters:
- `WIDTH`, 13: width of cycle, duty and phase values.
- `CHANNELS`, 4: number of PWM channels (≥1).
- `PHASE_INVERTED`, "TRUE": "TRUE" sets effective phase to (C−P) mod C; "FALSE" sets it to P.

Ports:
- `CLK`  in  1  system clock.
- `RST`  in  1  asynchronous, active-high reset.
- `SYNC`  in  1  restarts all channel counters at 0.
- `SET`  in  1  write strobe for `CYCLE` to channel `SET_CH`.
- `SET_CH`  in  $clog2(CHANNELS) (min 1)  target channel of `SET`.
- `CYCLE`  in  WIDTH  period in clocks.
- `DUTY`  in  CHANNELS*WIDTH  channel i at [i*WIDTH +: WIDTH].
- `PHASE`  in  CHANNELS*WIDTH  channel i at [i*WIDTH +: WIDTH].
- `PWM_OUT`  out  CHANNELS  registered PWM outputs.

## Operation
- Per channel i, the registers are: cycle C_i, counter t_i, shadow D_i and P_i. All reset to 0.
- Enabled when C_i ≥ 2. A disabled channel holds t_i at 0 and drives PWM_OUT[i] = 0.
- Counter: t ← t+1, wrapping from C−1 to 0. Counter priority, highest first: `RST`, then `SYNC` or `SET` to this channel (t ← 0), then increment.
- `SET` with SET_CH = i: C_i ← CYCLE, t_i ← 0. An out-of-range SET_CH is ignored.
- Shadow load: D_i and P_i sample the `DUTY` and `PHASE` slices on every edge where t_i becomes 0, whether by wrap, `SYNC` or `SET`. No other edge changes them.
- Phase handling:
  - Clamp: P' = min(P, C−1).
  - Effective start S = P' when `PHASE_INVERTED` is "FALSE".
  - Effective start S = (C−P') mod C when `PHASE_INVERTED` is "TRUE".
- Output: high when ((t − S) mod C) < D.
  - Compute t − S in WIDTH+1 bits and add C if negative.
  - D = 0 gives constant low.
  - D ≥ C gives constant high.
- `SYNC` together with `SET`: both take effect. The written channel gets its new C, and all counters restart at 0.

## Timing
- If t_i = x at the edge ending cycle k, then PWM_OUT[i] in cycle k+1 equals f(x, D_i, P_i, C_i). The latency is one register from the counter value.
- New duty/phase presented during a period takes effect at the next t = 0. The first affected output appears one cycle after that.
- After `SET`, t = 0 in the next cycle. The output follows the new cycle one cycle later.
- `RST` asserted mid-period clears everything immediately (asynchronously): PWM_OUT = 0, C = 0. Outputs stay 0 until channels are reconfigured by `SET`.
- PWM_OUT reset value: all zeros.

## Configuration
- `PWM_GEN_ARRAY_OE_EN` defined:
  - Adds input port `OE` (1 bit), placed after `RST`.
  - When `OE` = 0, the output register is loaded with 0 on each edge. Counters and shadows keep running unaffected.
  - `OE` → PWM_OUT latency is one cycle.
- `PWM_GEN_ARRAY_OE_EN` undefined: no `OE` port; outputs are always driven per Operation.

## Test plan
- Basic duty: PHASE_INVERTED="TRUE", SET ch0 with C=5000, D=2500, P=0. Expect PWM_OUT[0] high for 2500 clocks, then low for 2500, starting 1 clock after t=0; the pattern repeats.
- Inverted phase: same setup, P=1000, so S=4000. Expect high for t∈[4000,4999]∪[0,1499], 2500 clocks total. With PHASE_INVERTED="FALSE" and the same P, expect high for t∈[1000,3499].
- Mid-period update and per-channel independence:
  - Change D from 2500 to 1000 at t=1200. The current period keeps 2500 high clocks; the next has 1000.
  - Channel 1 is configured simultaneously (C=200, D=50) and is unaffected by channel 0 writes.
- Boundaries:
  - D=0 gives constant 0.
  - D=5000 and D=8191 give constant 1.
  - P=6000 with C=5000 behaves as P=4999.
  - C=1 or C=0 gives constant 0.
- SYNC and RST:
  - SYNC at t=3000 gives t=0 on all channels next cycle, with shadows reloaded.
  - SYNC coincident with SET of ch1 applies the new C on ch1.
  - RST pulse mid-period gives PWM_OUT=0 immediately and outputs stay 0 until SET.
- OE (macro defined): deassert `OE` for 300 clocks during a high phase. The output goes 0 one cycle later; after `OE` returns, the output resumes the unchanged counter-based pattern one cycle later.
